multicycle_ctrl: RTL
====================

# multicycle_ctrl

- Sequencing controller for the multi-cycle variant of the simple CPU.
- Fetches, decodes and executes the ISA subset one phase per cycle: R-type (ADD, SUB, AND, OR, SLT, NOR, SLL, SRL, SLLV, SRLV), ADDI, LUI, ORI, BEQ.
- Drives PC, IR, register-file and ALU controls over a shared ALU/register-file datapath.
- Counts retired instructions and halts on the all-zero end-of-program word or on an illegal encoding.

## Interface
- `PC_W`, 32: width of the retired-instruction counter.
- `clk_i` in 1: single clock, rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `instr_i` in 32: current IR contents.
- `zero_i` in 1: ALU zero flag, valid in EXEC.
- `ir_write_o` out 1: load IR from instruction memory.
- `pc_write_o` out 1: load PC.
- `pc_src_o` out 1: 0 = PC+4, 1 = branch target (PC+4 + sext(imm)<<2).
- `reg_write_o` out 1: register-file write enable.
- `reg_dst_o` out 1: 1 = rd, 0 = rt.
- `alu_src_b_o` out 1: 0 = rt data, 1 = extended immediate.
- `ext_sel_o` out 2: 00 = sign-extend, 01 = zero-extend, 10 = imm<<16.
- `shamt_sel_o` out 1: ALU A operand = instr[10:6] (SLL/SRL only).
- `alu_ctrl_o` out 4: ALU operation code.
- `retired_o` out PC_W: instructions completed since reset.
- `halted_o` out 1: end-of-program reached.
- `err_o` out 1: illegal opcode or funct.

## Operation
- Moore FSM. States: IDLE, FETCH, DECODE, EXEC, WB, HALT, ERR. All outputs decode from state + `instr_i`. Every output not listed for a state is 0.
- IDLE: reset state, all outputs 0. Goes to FETCH next cycle.
- FETCH: `ir_write_o`=1, `pc_write_o`=1, `pc_src_o`=0. Goes to DECODE.
- DECODE: no enables. Next state:
  - `instr_i`==0: HALT.
  - Opcode not in {111111, 110111, 001111, 001101, 000100}, or R-type funct not in the list below: ERR.
  - Otherwise: EXEC.
- EXEC: ALU controls valid.
  - BEQ: `alu_ctrl_o`=SUB, `pc_src_o`=1, `pc_write_o`=`zero_i`. `retired_o` increments. Goes to FETCH.
  - All others: go to WB.
- WB: EXEC's ALU controls held, `reg_write_o`=1. `retired_o` increments. Goes to FETCH.
- ALU codes:
  - AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111, NOR 1100
  - SLL 1000, SRL 1001, SLLV 1010, SRLV 1011
- Funct map (opcode 111111):
  - 010010 ADD, 010000 SUB, 010100 AND, 010110 OR, 100000 SLT, 010101 NOR
  - 000000 SLL, 000010 SRL, 000110 SLLV, 000100 SRLV
  - R-type controls: `reg_dst_o`=1, `alu_src_b_o`=0. SLL/SRL also set `shamt_sel_o`=1.
- I-type controls: `reg_dst_o`=0, `alu_src_b_o`=1.
  - ADDI: ADD, `ext_sel_o`=00.
  - ORI: OR, `ext_sel_o`=01.
  - LUI: ADD, `ext_sel_o`=10. Result is rs + imm<<16.
- HALT and ERR are absorbing: all enables 0; `halted_o`=1 and `err_o`=1 respectively. Only reset exits.
- `retired_o` wraps modulo 2^PC_W.

## Timing
- CPI: 4 for R/I-type, 3 for BEQ; the first FETCH occurs 1 cycle after reset release.
- Reset (`rst_n`=0 at a rising edge):
  - Next state IDLE; `retired_o`=0, `halted_o`=0, `err_o`=0.
  - `ir_write_o`, `pc_write_o` and `reg_write_o` are combinationally gated by `rst_n`. Reset mid-WB or mid-EXEC therefore commits no write in that cycle.
- `zero_i` is sampled combinationally in EXEC only. Its value in other states is ignored.
- `instr_i` must be stable from DECODE through WB. IR changes only on an `ir_write_o` edge.

## Structure
- `cpu_pkg`: opcode and funct constants, ALU code constants, `ext_sel` encodings, FSM state enum. Shared with the decoder, ALU and testbench.
- Sub-module `alu_ctrl_dec`: combinational {opcode, funct} to {`alu_ctrl_o`, `shamt_sel_o`, legal flag}. Instantiated once; the FSM uses its legal flag in DECODE.

## Test plan
- Reset release, IR=0x00000000: IDLE, FETCH, DECODE, then HALT at cycle 3. `halted_o`=1, `retired_o`=0, no `reg_write_o` pulse.
- ADDI r1,r0,5 (0xDC010005): FETCH/DECODE/EXEC/WB. `alu_ctrl_o`=0010, `ext_sel_o`=00, `reg_dst_o`=0. `reg_write_o` high in cycle 4 only; `retired_o`=1.
- BEQ with `zero_i`=1 in EXEC: `pc_write_o`=1, `pc_src_o`=1 in cycle 3. With `zero_i`=0: `pc_write_o`=0. Both cases: back to FETCH, no `reg_write_o`.
- Back-to-back SLL, SRLV, NOR, LUI: SLL gives `shamt_sel_o`=1, `alu_ctrl_o`=1000; SRLV 1011; NOR 1100; LUI `ext_sel_o`=10. `retired_o`=4 after 16 cycles.
- Illegal opcode 0x3E (R-type funct 111111 likewise): ERR after DECODE. `err_o`=1 held; no further FETCH.
- `rst_n` low in WB of ADD: `reg_write_o`=0 that cycle; IDLE next cycle, counters cleared.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared ISA, ALU-code and sequencing constants for the multi-cycle CPU.
// Used by the controller, its ALU-control decoder and the bench.
package cpu_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned OPC_W   = 6;
  localparam int unsigned FUNCT_W = 6;
  localparam int unsigned ALU_W   = 4;
  localparam int unsigned EXT_W   = 2;
  localparam int unsigned ST_W    = 3;

  // Primary opcodes
  localparam logic [OPC_W-1:0] OP_RTYPE = 6'b111111;
  localparam logic [OPC_W-1:0] OP_ADDI  = 6'b110111;
  localparam logic [OPC_W-1:0] OP_LUI   = 6'b001111;
  localparam logic [OPC_W-1:0] OP_ORI   = 6'b001101;
  localparam logic [OPC_W-1:0] OP_BEQ   = 6'b000100;

  // R-type function codes
  localparam logic [FUNCT_W-1:0] F_ADD  = 6'b010010;
  localparam logic [FUNCT_W-1:0] F_SUB  = 6'b010000;
  localparam logic [FUNCT_W-1:0] F_AND  = 6'b010100;
  localparam logic [FUNCT_W-1:0] F_OR   = 6'b010110;
  localparam logic [FUNCT_W-1:0] F_SLT  = 6'b100000;
  localparam logic [FUNCT_W-1:0] F_NOR  = 6'b010101;
  localparam logic [FUNCT_W-1:0] F_SLL  = 6'b000000;
  localparam logic [FUNCT_W-1:0] F_SRL  = 6'b000010;
  localparam logic [FUNCT_W-1:0] F_SLLV = 6'b000110;
  localparam logic [FUNCT_W-1:0] F_SRLV = 6'b000100;

  // ALU operation codes
  localparam logic [ALU_W-1:0] ALU_AND  = 4'b0000;
  localparam logic [ALU_W-1:0] ALU_OR   = 4'b0001;
  localparam logic [ALU_W-1:0] ALU_ADD  = 4'b0010;
  localparam logic [ALU_W-1:0] ALU_SUB  = 4'b0110;
  localparam logic [ALU_W-1:0] ALU_SLT  = 4'b0111;
  localparam logic [ALU_W-1:0] ALU_NOR  = 4'b1100;
  localparam logic [ALU_W-1:0] ALU_SLL  = 4'b1000;
  localparam logic [ALU_W-1:0] ALU_SRL  = 4'b1001;
  localparam logic [ALU_W-1:0] ALU_SLLV = 4'b1010;
  localparam logic [ALU_W-1:0] ALU_SRLV = 4'b1011;

  // Immediate extension selects
  localparam logic [EXT_W-1:0] EXT_SEXT = 2'b00;
  localparam logic [EXT_W-1:0] EXT_ZEXT = 2'b01;
  localparam logic [EXT_W-1:0] EXT_LUI  = 2'b10;

  // Sequencer states
  localparam logic [ST_W-1:0] ST_IDLE   = 3'd0;
  localparam logic [ST_W-1:0] ST_FETCH  = 3'd1;
  localparam logic [ST_W-1:0] ST_DECODE = 3'd2;
  localparam logic [ST_W-1:0] ST_EXEC   = 3'd3;
  localparam logic [ST_W-1:0] ST_WB     = 3'd4;
  localparam logic [ST_W-1:0] ST_HALT   = 3'd5;
  localparam logic [ST_W-1:0] ST_ERR    = 3'd6;

  // Datapath steering bundle held across EXEC and WB
  typedef struct packed {
    logic             reg_dst;
    logic             alu_src_b;
    logic [EXT_W-1:0] ext_sel;
    logic             shamt_sel;
    logic [ALU_W-1:0] alu_ctrl;
  } alu_ctl_t;

  function automatic logic [OPC_W-1:0] get_opcode(input logic [INSTR_W-1:0] instr);
    return instr[31:26];
  endfunction

  function automatic logic [FUNCT_W-1:0] get_funct(input logic [INSTR_W-1:0] instr);
    return instr[5:0];
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath bundle: IR contents and zero flag in, sequencing
// and ALU controls out. master = controller, slave = datapath.
interface multicycle_ctrl_if
  import cpu_pkg::*;
#(
  parameter int unsigned PC_W = 32
);

  logic [INSTR_W-1:0] instr_i;
  logic               zero_i;
  logic               ir_write_o;
  logic               pc_write_o;
  logic               pc_src_o;
  logic               reg_write_o;
  logic               reg_dst_o;
  logic               alu_src_b_o;
  logic [EXT_W-1:0]   ext_sel_o;
  logic               shamt_sel_o;
  logic [ALU_W-1:0]   alu_ctrl_o;
  logic [PC_W-1:0]    retired_o;
  logic               halted_o;
  logic               err_o;

  modport master (
    input  instr_i, zero_i,
    output ir_write_o, pc_write_o, pc_src_o, reg_write_o, reg_dst_o,
           alu_src_b_o, ext_sel_o, shamt_sel_o, alu_ctrl_o,
           retired_o, halted_o, err_o
  );

  modport slave (
    output instr_i, zero_i,
    input  ir_write_o, pc_write_o, pc_src_o, reg_write_o, reg_dst_o,
           alu_src_b_o, ext_sel_o, shamt_sel_o, alu_ctrl_o,
           retired_o, halted_o, err_o
  );

endinterface

// File: rtl/alu_ctrl_dec.sv
// Combinational {opcode, funct} -> ALU operation, shift-amount select and
// legality of the encoding.
module alu_ctrl_dec
  import cpu_pkg::*;
(
  input  logic [OPC_W-1:0]   opcode,
  input  logic [FUNCT_W-1:0] funct,
  output logic [ALU_W-1:0]   alu_ctrl,
  output logic               shamt_sel,
  output logic               legal
);

  always_comb begin
    alu_ctrl  = ALU_AND;
    shamt_sel = 1'b0;
    legal     = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        legal = 1'b1;
        case (funct)
          F_ADD:  alu_ctrl = ALU_ADD;
          F_SUB:  alu_ctrl = ALU_SUB;
          F_AND:  alu_ctrl = ALU_AND;
          F_OR:   alu_ctrl = ALU_OR;
          F_SLT:  alu_ctrl = ALU_SLT;
          F_NOR:  alu_ctrl = ALU_NOR;
          F_SLL: begin
            alu_ctrl  = ALU_SLL;
            shamt_sel = 1'b1;
          end
          F_SRL: begin
            alu_ctrl  = ALU_SRL;
            shamt_sel = 1'b1;
          end
          F_SLLV: alu_ctrl = ALU_SLLV;
          F_SRLV: alu_ctrl = ALU_SRLV;
          default: legal = 1'b0;
        endcase
      end
      // LUI is rs + (imm << 16), so it rides the adder
      OP_ADDI, OP_LUI: begin
        legal    = 1'b1;
        alu_ctrl = ALU_ADD;
      end
      OP_ORI: begin
        legal    = 1'b1;
        alu_ctrl = ALU_OR;
      end
      OP_BEQ: begin
        legal    = 1'b1;
        alu_ctrl = ALU_SUB;
      end
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Moore sequencer for the multi-cycle CPU: FETCH/DECODE/EXEC/WB phases,
// retired-instruction counter, and absorbing HALT/ERR states.
module multicycle_ctrl
  import cpu_pkg::*;
#(
  parameter int unsigned PC_W = 32
) (
  input  logic                clk_i,
  input  logic                rst_n,
  multicycle_ctrl_if.master   bus
);

  logic [ST_W-1:0]    state_q;
  logic [ST_W-1:0]    state_d;
  logic [PC_W-1:0]    retired_q;

  logic [OPC_W-1:0]   opcode;
  logic [FUNCT_W-1:0] funct;
  logic [ALU_W-1:0]   dec_alu;
  logic               dec_shamt;
  logic               dec_legal;
  logic               is_beq;
  logic               retire;

  alu_ctl_t           ctl;
  alu_ctl_t           ctl_out;
  logic               ir_write_c;
  logic               pc_write_c;
  logic               pc_src_c;
  logic               reg_write_c;

  assign opcode = get_opcode(bus.instr_i);
  assign funct  = get_funct(bus.instr_i);
  assign is_beq = (opcode == OP_BEQ);

  alu_ctrl_dec u_alu_ctrl_dec (
    .opcode    (opcode),
    .funct     (funct),
    .alu_ctrl  (dec_alu),
    .shamt_sel (dec_shamt),
    .legal     (dec_legal)
  );

  // Operand steering for the instruction held in IR
  always_comb begin
    ctl           = '0;
    ctl.alu_ctrl  = dec_alu;
    ctl.shamt_sel = dec_shamt;
    case (opcode)
      OP_RTYPE: ctl.reg_dst = 1'b1;
      OP_ADDI: begin
        ctl.alu_src_b = 1'b1;
        ctl.ext_sel   = EXT_SEXT;
      end
      OP_ORI: begin
        ctl.alu_src_b = 1'b1;
        ctl.ext_sel   = EXT_ZEXT;
      end
      OP_LUI: begin
        ctl.alu_src_b = 1'b1;
        ctl.ext_sel   = EXT_LUI;
      end
      default: ;
    endcase
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   state_d = ST_FETCH;
      ST_FETCH:  state_d = ST_DECODE;
      ST_DECODE: begin
        if (bus.instr_i == '0) begin
          state_d = ST_HALT;
        end else if (!dec_legal) begin
          state_d = ST_ERR;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC:   state_d = is_beq ? ST_FETCH : ST_WB;
      ST_WB:     state_d = ST_FETCH;
      ST_HALT:   state_d = ST_HALT;
      ST_ERR:    state_d = ST_ERR;
      default:   state_d = ST_ERR;
    endcase
  end

  // Per-state output decode; ALU controls are live in EXEC and held in WB
  always_comb begin
    ir_write_c  = 1'b0;
    pc_write_c  = 1'b0;
    pc_src_c    = 1'b0;
    reg_write_c = 1'b0;
    ctl_out     = '0;
    case (state_q)
      ST_FETCH: begin
        ir_write_c = 1'b1;
        pc_write_c = 1'b1;
      end
      ST_EXEC: begin
        ctl_out = ctl;
        if (is_beq) begin
          pc_src_c   = 1'b1;
          pc_write_c = bus.zero_i;
        end
      end
      ST_WB: begin
        ctl_out     = ctl;
        reg_write_c = 1'b1;
      end
      default: ;
    endcase
  end

  assign retire = ((state_q == ST_EXEC) && is_beq) || (state_q == ST_WB);

  always_ff @(posedge clk_i) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      if (retire) begin
        retired_q <= retired_q + PC_W'(1);
      end
    end
  end

  // Architectural write enables are suppressed while reset is asserted
  assign bus.ir_write_o  = ir_write_c & rst_n;
  assign bus.pc_write_o  = pc_write_c & rst_n;
  assign bus.reg_write_o = reg_write_c & rst_n;
  assign bus.pc_src_o    = pc_src_c;
  assign bus.reg_dst_o   = ctl_out.reg_dst;
  assign bus.alu_src_b_o = ctl_out.alu_src_b;
  assign bus.ext_sel_o   = ctl_out.ext_sel;
  assign bus.shamt_sel_o = ctl_out.shamt_sel;
  assign bus.alu_ctrl_o  = ctl_out.alu_ctrl;
  assign bus.retired_o   = retired_q;
  assign bus.halted_o    = (state_q == ST_HALT);
  assign bus.err_o       = (state_q == ST_ERR);

endmodule
